// File: rtl/wbrdwr_sched.sv
`default_nettype none
// ============================================================================
// Module   : wbrdwr_sched
// Purpose  : Shares one pipelined Wishbone slave port between the read-side
//            master (A, always we=0) and the write-side master (B, always
//            we=1) of an AXI-lite bridge. Idle arbitration is round-robin.
//            An owner that has had MAXHOLD strobes accepted while the other
//            side waits is stalled, drained of outstanding requests, given
//            one cycle of cyc=0, and then the bus is handed over.
// Optional : define WBSCHED_STATS_EN to add o_preempt_cnt, a 16-bit
//            saturating count of entries into the drain state.
// Ports    : i_clk, i_reset_n       clock, async active-low reset
//            i_a_* / o_a_*          read master WB slave-side interface
//            i_b_* / o_b_*          write master WB slave-side interface
//            o_wb_* / i_wb_*        shared WB master-side interface
//            o_grant                {B,A} one-hot owner, 00 in IDLE/GAP
// Revision : 1.0  initial release
// ============================================================================
module wbrdwr_sched #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int LGOUT   = 4,
  parameter int MAXHOLD = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  // read master (A)
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  // write master (B)
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  // shared bus
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  output logic [1:0]      o_grant
`ifdef WBSCHED_STATS_EN
  ,
  output logic [15:0]     o_preempt_cnt
`endif
);

  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [LGOUT-1:0] OUT_MAX  = '1;
  localparam logic [LGOUT-1:0] OUT_ONE  = LGOUT'(1);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(MAXHOLD);
  localparam logic [HW-1:0]    HOLD_ONE = HW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OWN_A = 3'd1,
    S_OWN_B = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             last_q,  last_d;   // 1: B was granted last
  logic             owner_q, owner_d;  // 1: B owns (valid in OWN/DRAIN/GAP)
  logic [LGOUT-1:0] outst_q, outst_d;
  logic [HW-1:0]    hold_q,  hold_d;

  logic own_cyc, own_stb, other_cyc;
  logic active, owning;
  logic preempt, force_stall;
  logic wb_stb, accept, ack_in, err_in, own_stall;

`ifdef WBSCHED_STATS_EN
  logic [15:0] pcnt_q, pcnt_d;
  assign o_preempt_cnt = pcnt_q;
`endif

  // --------------------------------------------------------------------------
  // Output muxing off the registered owner/state
  // --------------------------------------------------------------------------
  always_comb begin
    own_cyc   = owner_q ? i_b_cyc : i_a_cyc;
    own_stb   = owner_q ? i_b_stb : i_a_stb;
    other_cyc = owner_q ? i_a_cyc : i_b_cyc;

    owning = (state_q == S_OWN_A) || (state_q == S_OWN_B);
    active = owning || (state_q == S_DRAIN);

    // Hold the owner off once the in-flight counter is full (so it never
    // wraps) or once it has used up its turn while the other side waits.
    preempt     = (hold_q >= HOLD_MAX) && other_cyc;
    force_stall = (outst_q == OUT_MAX) || preempt;

    wb_stb = owning && own_cyc && own_stb && !force_stall;
    accept = wb_stb && !i_wb_stall;

    // Returns are only forwarded while the owner still holds cyc; anything
    // arriving after it dropped cyc belongs to an abandoned cycle.
    ack_in = active && own_cyc && i_wb_ack;
    err_in = active && own_cyc && i_wb_err;

    own_stall = owning ? (i_wb_stall || force_stall) : 1'b1;

    o_wb_cyc  = active && own_cyc;
    o_wb_stb  = wb_stb;
    o_wb_we   = active && owner_q;
    o_wb_addr = active ? (owner_q ? i_b_addr : i_a_addr) : '0;
    o_wb_data = (active && owner_q) ? i_b_data : '0;
    o_wb_sel  = active ? (owner_q ? i_b_sel : i_a_sel) : '0;

    o_a_stall = (active && !owner_q) ? own_stall : 1'b1;
    o_b_stall = (active &&  owner_q) ? own_stall : 1'b1;
    o_a_ack   = !owner_q && ack_in;
    o_b_ack   =  owner_q && ack_in;
    o_a_err   = !owner_q && err_in;
    o_b_err   =  owner_q && err_in;

    o_grant = active ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    outst_d = outst_q;
    hold_d  = hold_q;
`ifdef WBSCHED_STATS_EN
    pcnt_d  = pcnt_q;
`endif

    // In-flight tracking; an accept and an ack in one cycle cancel out.
    if (accept && !ack_in) begin
      outst_d = outst_q + OUT_ONE;
    end else if (!accept && ack_in && (outst_q != '0)) begin
      outst_d = outst_q - OUT_ONE;
    end

    // Turn length only matters while someone is waiting for the bus.
    if (!other_cyc) begin
      hold_d = '0;
    end else if (accept && (hold_q < HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        outst_d = '0;
        hold_d  = '0;
        if (i_a_cyc && i_b_cyc) begin
          owner_d = !last_q;
          last_d  = !last_q;
          state_d = last_q ? S_OWN_A : S_OWN_B;
        end else if (i_a_cyc) begin
          owner_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_OWN_A;
        end else if (i_b_cyc) begin
          owner_d = 1'b1;
          last_d  = 1'b1;
          state_d = S_OWN_B;
        end
      end

      S_OWN_A, S_OWN_B: begin
        if (!own_cyc) begin
          outst_d = '0;
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (err_in) begin
          outst_d = '0;
          state_d = S_GAP;
        end else if (preempt) begin
          state_d = S_DRAIN;
`ifdef WBSCHED_STATS_EN
          if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
`endif
        end
      end

      S_DRAIN: begin
        if (!own_cyc) begin
          outst_d = '0;
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (err_in) begin
          outst_d = '0;
          state_d = S_GAP;
        end else if (outst_d == '0) begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        outst_d = '0;
        hold_d  = '0;
        // After an error the other side may not be waiting; in that case
        // fall back to IDLE and let normal arbitration pick again.
        if (other_cyc) begin
          owner_d = !owner_q;
          last_d  = !owner_q;
          state_d = owner_q ? S_OWN_A : S_OWN_B;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        outst_d = '0;
        hold_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      outst_q <= '0;
      hold_q  <= '0;
`ifdef WBSCHED_STATS_EN
      pcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      outst_q <= outst_d;
      hold_q  <= hold_d;
`ifdef WBSCHED_STATS_EN
      pcnt_q  <= pcnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wbrdwr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbrdwr_sched
// Purpose  : Directed, self-checking bench for wbrdwr_sched. A table of
//            per-cycle {inputs, expected control outputs} covers arbitration
//            and slave stalls; hand-written sequences cover preemption,
//            error abort, in-flight limit and reset while draining.
// Revision : 1.0  initial release
// ============================================================================
module tb_wbrdwr_sched;

  localparam int AW = 26;
  localparam int DW = 32;

  // {grant[1:0], cyc, stb, we, a_stall, a_ack, a_err, b_stall, b_ack, b_err}
  localparam logic [10:0] E_IDLE = 11'b00_000_100_100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_cyc, a_stb, b_cyc, b_stb;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   b_data;
  logic [DW/8-1:0] a_sel, b_sel;
  logic            a_stall, a_ack, a_err, b_stall, b_ack, b_err;
  logic            wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [DW/8-1:0] wb_sel;
  logic            wb_stall, wb_ack, wb_err;
  logic [1:0]      grant;
  logic [10:0]     ctl;
`ifdef WBSCHED_STATS_EN
  logic [15:0]     pcnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wbrdwr_sched #(.AW(AW), .DW(DW), .LGOUT(4), .MAXHOLD(8)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_a_cyc    (a_cyc),
    .i_a_stb    (a_stb),
    .i_a_addr   (a_addr),
    .i_a_sel    (a_sel),
    .o_a_stall  (a_stall),
    .o_a_ack    (a_ack),
    .o_a_err    (a_err),
    .i_b_cyc    (b_cyc),
    .i_b_stb    (b_stb),
    .i_b_addr   (b_addr),
    .i_b_data   (b_data),
    .i_b_sel    (b_sel),
    .o_b_stall  (b_stall),
    .o_b_ack    (b_ack),
    .o_b_err    (b_err),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_data),
    .o_wb_sel   (wb_sel),
    .i_wb_stall (wb_stall),
    .i_wb_ack   (wb_ack),
    .i_wb_err   (wb_err),
    .o_grant    (grant)
`ifdef WBSCHED_STATS_EN
    ,
    .o_preempt_cnt (pcnt)
`endif
  );

  assign ctl = {grant, wb_cyc, wb_stb, wb_we, a_stall, a_ack, a_err,
                b_stall, b_ack, b_err};

  typedef struct {
    logic [6:0]  in;   // {a_cyc, a_stb, b_cyc, b_stb, wb_stall, wb_ack, wb_err}
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {a_cyc, a_stb, b_cyc, b_stb, wb_stall, wb_ack, wb_err} = v;
  endtask

  // Apply inputs just after a rising edge, check combinational outputs on
  // the following falling edge.
  task automatic apply_chk(input string name, input logic [6:0] v, input logic [10:0] e);
    drive(v);
    @(negedge clk);
    chk(name, 32'(ctl), 32'(e));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Arbitration / slave-stall / late-ack table
    tbl[0]  = '{7'b0000000, E_IDLE};
    tbl[1]  = '{7'b1010000, E_IDLE};               // both raise cyc
    tbl[2]  = '{7'b1110000, 11'b01_110_000_100};   // A granted first
    tbl[3]  = '{7'b1010010, 11'b01_100_010_100};
    tbl[4]  = '{7'b0010000, 11'b01_000_000_100};   // A drops cyc
    tbl[5]  = '{7'b0010000, E_IDLE};
    tbl[6]  = '{7'b1011100, 11'b10_111_100_100};   // slave stalls B x5
    tbl[7]  = '{7'b1011100, 11'b10_111_100_100};
    tbl[8]  = '{7'b1011100, 11'b10_111_100_100};
    tbl[9]  = '{7'b1011100, 11'b10_111_100_100};
    tbl[10] = '{7'b1011100, 11'b10_111_100_100};
    tbl[11] = '{7'b1011000, 11'b10_111_100_000};
    tbl[12] = '{7'b1010010, 11'b10_101_100_010};
    tbl[13] = '{7'b1000000, 11'b10_001_100_000};   // B drops cyc
    tbl[14] = '{7'b1000000, E_IDLE};
    tbl[15] = '{7'b1000000, 11'b01_100_000_100};
    tbl[16] = '{7'b0000010, 11'b01_000_000_100};   // late ack swallowed
    tbl[17] = '{7'b0000010, E_IDLE};

    a_addr = 26'h1234567;
    b_addr = 26'h2ABCDEF;
    b_data = 32'hDEADBEEF;
    a_sel  = 4'h3;
    b_sel  = 4'hC;
    drive(7'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl), 32'(E_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply_chk($sformatf("tbl[%0d]", i), tbl[i].in, tbl[i].exp);
      tick();
    end

    // ---- Preemption: A gets 8 strobes, B waiting ----
    apply_chk("pre_idle", 7'b1000000, E_IDLE);
    tick();
    for (int k = 0; k < 8; k++) begin
      apply_chk($sformatf("pre_acc%0d", k), {5'b11100, (k > 0), 1'b0},
                {5'b01_110, 1'b0, (k > 0), 1'b0, 3'b100});
      if (k == 0) begin
        chk("pre_addr", 32'(wb_addr), 32'(a_addr));
        chk("pre_sel",  32'(wb_sel),  32'(a_sel));
        chk("pre_data", wb_data, 32'h0);
      end
      tick();
    end
    apply_chk("pre_9th_stall", 7'b1110010, 11'b01_100_110_100);
    tick();
    apply_chk("pre_drain",     7'b1110000, 11'b01_100_100_100);
    tick();
    apply_chk("pre_gap",       7'b1110000, E_IDLE);
    tick();
    apply_chk("pre_grant_b",   7'b0010000, 11'b10_101_100_000);
    tick();
    apply_chk("pre_b_drop",    7'b0000000, 11'b10_001_100_000);
    tick();

    // ---- Error abort on B with 3 outstanding, A waiting ----
    apply_chk("err_idle", 7'b0010000, E_IDLE);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply_chk($sformatf("err_acc%0d", k), 7'b1011000, 11'b10_111_100_000);
      if (k == 0) begin
        chk("err_addr", 32'(wb_addr), 32'(b_addr));
        chk("err_data", wb_data, b_data);
        chk("err_sel",  32'(wb_sel), 32'(b_sel));
      end
      tick();
    end
    apply_chk("err_pulse",   7'b1010001, 11'b10_101_100_001);
    tick();
    apply_chk("err_gap",     7'b1010000, E_IDLE);
    tick();
    apply_chk("err_grant_a", 7'b1000000, 11'b01_100_000_100);
    tick();

    // ---- In-flight limit: 15 reads without acks ----
    for (int k = 0; k < 15; k++) begin
      apply_chk($sformatf("lim_acc%0d", k), 7'b1100000, 11'b01_110_000_100);
      tick();
    end
    apply_chk("lim_16th_stall", 7'b1100000, 11'b01_100_100_100);
    tick();
    apply_chk("lim_ack",        7'b1100010, 11'b01_100_110_100);
    tick();
    apply_chk("lim_reaccept",   7'b1100000, 11'b01_110_000_100);
    tick();
    apply_chk("lim_drop",       7'b0000000, 11'b01_000_100_100);
    tick();
    apply_chk("lim_idle",       7'b0000000, E_IDLE);
    tick();

    // ---- Reset while draining ----
    apply_chk("rst_idle", 7'b1000000, E_IDLE);
    tick();
    for (int k = 0; k < 8; k++) begin
      apply_chk($sformatf("rst_acc%0d", k), 7'b1110000, 11'b01_110_000_100);
      tick();
    end
    apply_chk("rst_pre_stall", 7'b1110000, 11'b01_100_100_100);
    tick();
    apply_chk("rst_draining",  7'b1110000, 11'b01_100_100_100);
`ifdef WBSCHED_STATS_EN
    chk("stats_two", 32'(pcnt), 32'd2);
`endif
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl",  32'(ctl), 32'(E_IDLE));
    chk("rst_async_addr", 32'(wb_addr), 32'h0);
    chk("rst_async_data", wb_data, 32'h0);
`ifdef WBSCHED_STATS_EN
    chk("stats_zero", 32'(pcnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    apply_chk("rst_after_idle", 7'b1110000, E_IDLE);
    tick();
    apply_chk("rst_after_a",    7'b1110000, 11'b01_110_000_100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
